// File: rtl/ps2_led_command.sv
// PS/2 host-to-keyboard LED command sequencer: sends 0xED then the LED byte,
// each gated on a keyboard ACK, with per-sequence retry on RESEND or timeout.
module ps2_led_command #(
  parameter int unsigned TIMEOUT_CYCLES = 540000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       reset_low,
  input  logic       set_status,
  input  logic       set_status_caps_lock,
  input  logic       set_status_num_lock,
  input  logic       set_status_scroll_lock,
  input  logic       acknowledge,
  input  logic       resend,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_byte,
  output logic       busy,
  output logic       error
);

  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [7:0]         CMD_SET_LEDS = 8'hED;
  localparam logic [TIMER_W-1:0] TIMER_LAST   = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX    = '1;
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    WAIT_CMD_ACK,
    SEND_DATA,
    WAIT_DATA_ACK
  } state_e;

  state_e             state_q, state_d;
  logic               pending_q, pending_d;
  logic [7:0]         led_q, led_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               busy_q, busy_d;
  logic               error_q, error_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      led_q      <= 8'h00;
      retry_q    <= '0;
      timer_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      led_q      <= led_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    led_d     = led_q;
    retry_d   = retry_q;
    timer_d   = timer_q;
    tx_byte_d = tx_byte_q;
    error_d   = 1'b0;

    if (set_status) begin
      led_d     = {5'b0, set_status_caps_lock, set_status_num_lock, set_status_scroll_lock};
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          pending_d = set_status;
          retry_d   = '0;
          tx_byte_d = CMD_SET_LEDS;
          state_d   = SEND_CMD;
        end
      end
      SEND_CMD: begin
        if (tx_ready) begin
          timer_d = '0;
          state_d = WAIT_CMD_ACK;
        end
      end
      SEND_DATA: begin
        if (tx_ready) begin
          timer_d = '0;
          state_d = WAIT_DATA_ACK;
        end
      end
      WAIT_CMD_ACK, WAIT_DATA_ACK: begin
        if (timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;
        if (acknowledge) begin
          if (state_q == WAIT_CMD_ACK) begin
            tx_byte_d = led_q;
            state_d   = SEND_DATA;
          end else begin
            state_d = IDLE;
          end
        end else if (resend || (timer_q == TIMER_LAST)) begin
          // tx_byte_q still holds the byte being retried
          if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + 1'b1;
            state_d = (state_q == WAIT_CMD_ACK) ? SEND_CMD : SEND_DATA;
          end else begin
            error_d   = 1'b1;
            pending_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tx_valid_d = (state_d == SEND_CMD) || (state_d == SEND_DATA);
    busy_d     = (state_d != IDLE);
  end

  assign tx_valid = tx_valid_q;
  assign tx_byte  = tx_byte_q;
  assign busy     = busy_q;
  assign error    = error_q;

endmodule

// File: tb/tb_ps2_led_command.sv
// Scoreboard bench for ps2_led_command: expected bytes queued per scenario,
// transmitted bytes captured at each handshake and compared in order.
module tb_ps2_led_command;

  logic       clk = 1'b0;
  logic       reset_low = 1'b0;
  logic       set_status = 1'b0;
  logic       caps = 1'b0, num = 1'b0, scroll = 1'b0;
  logic       acknowledge = 1'b0;
  logic       resend = 1'b0;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_byte;
  logic       busy;
  logic       error;

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  ps2_led_command #(.TIMEOUT_CYCLES(16), .MAX_RETRIES(3)) dut (
    .clk                    (clk),
    .reset_low              (reset_low),
    .set_status             (set_status),
    .set_status_caps_lock   (caps),
    .set_status_num_lock    (num),
    .set_status_scroll_lock (scroll),
    .acknowledge            (acknowledge),
    .resend                 (resend),
    .tx_valid               (tx_valid),
    .tx_ready               (tx_ready),
    .tx_byte                (tx_byte),
    .busy                   (busy),
    .error                  (error)
  );

  always #5 clk = ~clk;

  // Capture every byte that will be accepted on the coming rising edge
  always @(negedge clk) begin
    if (reset_low && tx_valid && tx_ready) obs_q.push_back(tx_byte);
    if (reset_low && error) err_pulses++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_status(input logic c, input logic n, input logic s);
    caps = c; num = n; scroll = s; set_status = 1'b1;
    tick(1);
    set_status = 1'b0;
  endtask

  task automatic pulse_ack();
    acknowledge = 1'b1;
    tick(1);
    acknowledge = 1'b0;
  endtask

  task automatic pulse_resend();
    resend = 1'b1;
    tick(1);
    resend = 1'b0;
  endtask

  task automatic wait_hs(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset_low = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got=%h exp=00", tx_byte); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", error); end
    tick(2);
    reset_low = 1'b1;
    tick(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    bit ok;
    int e0;
    logic [7:0] e, o;
    e0 = err_pulses;
    exp_q.push_back(8'hED); exp_q.push_back(8'h05);
    tx_ready = 1'b1;
    pulse_status(1'b1, 1'b0, 1'b1);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL basic_latency1 tx_valid got=%b exp=0", tx_valid); end
    tick(1);
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL basic_latency2 tx_valid got=%b exp=1", tx_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
    for (int k = 0; k < 2; k++) begin
      wait_hs(50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_handshake%0d got=timeout exp=transfer", k); end
      tick(4);
      pulse_ack();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
    tick(5);
    checks++; if (err_pulses !== e0) begin errors++; $display("FAIL basic_error got=%0d exp=%0d", err_pulses, e0); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL basic_byte got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [7:0] e, o;
    exp_q.push_back(8'hED); exp_q.push_back(8'h02);
    exp_q.push_back(8'hED); exp_q.push_back(8'h02);
    tx_ready = 1'b0;
    pulse_status(1'b0, 1'b0, 1'b0);
    tick(1);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_byte !== 8'hED) begin
        errors++; $display("FAIL bp_stall%0d got=%b/%h exp=1/ed", i, tx_valid, tx_byte);
      end
      if (i == 5) begin caps = 1'b0; num = 1'b1; scroll = 1'b0; set_status = 1'b1; end
      tick(1);
      set_status = 1'b0;
    end
    tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_hs(50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_handshake%0d got=timeout exp=transfer", k); end
      tick(4);
      pulse_ack();
    end
    tick(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end got=%b exp=0", busy); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL bp_byte got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_resend();
    bit ok;
    logic [7:0] e, o;
    exp_q.push_back(8'hED); exp_q.push_back(8'h05); exp_q.push_back(8'h05);
    pulse_status(1'b1, 1'b0, 1'b1);
    wait_hs(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rs_cmd got=timeout exp=transfer"); end
    tick(4); pulse_ack();
    wait_hs(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rs_data got=timeout exp=transfer"); end
    tick(4); pulse_resend();
    wait_hs(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rs_retry got=timeout exp=transfer"); end
    tick(4); pulse_ack();
    tick(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rs_busy_end got=%b exp=0", busy); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rs_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL rs_byte got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout();
    bit ok;
    int e0, n;
    logic [7:0] e, o;
    e0 = err_pulses;
    repeat (4) exp_q.push_back(8'hED);
    pulse_status(1'b0, 1'b1, 1'b1);
    wait_hs(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_first got=timeout exp=transfer"); end
    for (int r = 1; r <= 3; r++) begin
      n = 0;
      while (!tx_valid && n < 100) begin n++; tick(1); end
      checks++; if (n !== 16) begin errors++; $display("FAIL to_spacing%0d got=%0d exp=16", r, n); end
      wait_hs(50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL to_retry%0d got=timeout exp=transfer", r); end
    end
    tick(20);
    checks++; if (err_pulses !== e0 + 1) begin errors++; $display("FAIL to_error_pulses got=%0d exp=%0d", err_pulses, e0 + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy got=%b exp=0", busy); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL to_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL to_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL to_byte got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_coalesce();
    bit ok;
    logic [7:0] e, o;
    exp_q.push_back(8'hED); exp_q.push_back(8'h01);
    exp_q.push_back(8'hED); exp_q.push_back(8'h01);
    pulse_status(1'b1, 1'b1, 1'b1);
    wait_hs(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL co_cmd got=timeout exp=transfer"); end
    pulse_status(1'b1, 1'b0, 1'b0);
    pulse_status(1'b0, 1'b0, 1'b1);
    tick(2); pulse_ack();
    for (int k = 0; k < 3; k++) begin
      wait_hs(50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL co_handshake%0d got=timeout exp=transfer", k); end
      tick(4); pulse_ack();
    end
    tick(40);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL co_busy_end got=%b exp=0", busy); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL co_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL co_byte got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_async_reset();
    bit ok;
    pulse_status(1'b1, 1'b0, 1'b1);
    wait_hs(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ar_cmd got=timeout exp=transfer"); end
    tx_ready = 1'b0;
    tick(4); pulse_ack();
    checks++; if (tx_valid !== 1'b1 || tx_byte !== 8'h05) begin errors++; $display("FAIL ar_in_data got=%b/%h exp=1/05", tx_valid, tx_byte); end
    obs_q.delete(); exp_q.delete();
    #2 reset_low = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ar_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy got=%b exp=0", busy); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL ar_tx_byte got=%h exp=00", tx_byte); end
    tick(2);
    reset_low = 1'b1;
    tx_ready = 1'b1;
    tick(30);
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL ar_no_tx got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy_after got=%b exp=0", busy); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_resend();
    test_timeout();
    test_coalesce();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
